// File: rtl/gate_truth_table_checker_if.sv
// Bundles the checker's start/result signals and the gate-bank stimulus/response lines.
// No storage; every signal is driven by exactly one side.
// The master modport belongs to the controller and gate bank; the slave modport belongs to the checker.
interface gate_truth_table_checker_if;
  logic       start;
  logic [5:0] gate_y;
  logic       stim_a;
  logic       stim_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [5:0] fail_mask;
  logic [1:0] fail_vec;
  logic [4:0] fail_count;

  modport master (
    output start, gate_y,
    input  stim_a, stim_b, busy, done, pass, fail_mask, fail_vec, fail_count
  );

  modport slave (
    input  start, gate_y,
    output stim_a, stim_b, busy, done, pass, fail_mask, fail_vec, fail_count
  );
endinterface

// File: rtl/gate_truth_table_checker.sv
// Self-test sequencer: walks {a,b} through 00,01,10,11 into the gate bank and checks the six outputs.
// Latency: a full run asserts done 4*(SETTLE_CYCLES+1) edges after the edge that accepts start.
// Backpressure: none; start is only looked at in IDLE, so starts while busy or in DONE are dropped.
module gate_truth_table_checker #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned STOP_ON_FAIL  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  gate_truth_table_checker_if.slave bus
);

  // The settle counter only needs to hold SETTLE_CYCLES-1.
  localparam int unsigned   CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]    state;
  logic [1:0]    vec;
  logic [CW-1:0] cnt;
  logic [5:0]    fail_mask;
  logic [1:0]    fail_vec;
  logic [4:0]    fail_count;
  logic          pass;

  logic          busy;
  logic [5:0]    expected;
  logic [5:0]    mism;
  logic [4:0]    mism_count;
  logic          last_check;

  // Number of gates that disagree on the vector being checked.
  function automatic logic [4:0] popcount6(input logic [5:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 6; i++) begin
      c = c + 5'(v[i]);
    end
    return c;
  endfunction

  // Truth-table reference for the current vector and the resulting per-gate mismatches.
  always_comb begin
    expected   = {vec[1] ^ vec[0],
                  ~(vec[1] | vec[0]),
                  ~(vec[1] & vec[0]),
                  ~vec[1],
                  vec[1] | vec[0],
                  vec[1] & vec[0]};
    mism       = bus.gate_y ^ expected;
    mism_count = popcount6(mism);
    last_check = (vec == 2'b11) || ((STOP_ON_FAIL != 0) && (mism != 6'd0));
  end

  // Sequencer: accept start, hold each vector for the settle time, check, then report.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      vec        <= 2'b00;
      cnt        <= '0;
      fail_mask  <= 6'd0;
      fail_vec   <= 2'b00;
      fail_count <= 5'd0;
      pass       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // Results of the previous run stay visible here until a new run is accepted.
          if (bus.start) begin
            state      <= S_SETTLE;
            vec        <= 2'b00;
            cnt        <= CNT_LOAD;
            fail_mask  <= 6'd0;
            fail_vec   <= 2'b00;
            fail_count <= 5'd0;
            pass       <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (cnt == '0) begin
            state <= S_CHECK;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_CHECK: begin
          fail_mask  <= fail_mask | mism;
          fail_count <= fail_count + mism_count;
          // Only the first failing vector is recorded.
          if ((fail_mask == 6'd0) && (mism != 6'd0)) begin
            fail_vec <= vec;
          end
          if (last_check) begin
            state <= S_DONE;
          end else begin
            vec   <= vec + 2'b01;
            cnt   <= CNT_LOAD;
            state <= S_SETTLE;
          end
        end
        S_DONE: begin
          // fail_mask already includes the final CHECK by the time we get here.
          pass  <= (fail_mask == 6'd0);
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Stimulus is only driven while the run is active; it parks at 00 otherwise.
  always_comb begin
    busy       = (state == S_SETTLE) || (state == S_CHECK);
    bus.busy   = busy;
    bus.done   = (state == S_DONE);
    bus.stim_a = busy & vec[1];
    bus.stim_b = busy & vec[0];
  end

  assign bus.pass       = pass;
  assign bus.fail_mask  = fail_mask;
  assign bus.fail_vec   = fail_vec;
  assign bus.fail_count = fail_count;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Bench for gate_truth_table_checker: three instances (settle 1 / settle 1 stop-on-fail / settle 3),
// each wrapped by a fault-injectable gate bank; the third bank delays its outputs by two cycles.
module tb_gate_truth_table_checker;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  localparam int LIMIT = 100;

  int checks   = 0;
  int failures = 0;

  int settle_of [3] = '{1, 1, 3};
  bit stop_of   [3] = '{1'b0, 1'b1, 1'b0};

  logic       start_r [3];
  logic [5:0] sa0     [3];
  logic [5:0] inv     [3];

  logic [1:0] stim_w  [3];
  logic       busy_w  [3];
  logic       done_w  [3];
  logic       pass_w  [3];
  logic [5:0] fmask_w [3];
  logic [1:0] fvec_w  [3];
  logic [4:0] fcnt_w  [3];

  // Ideal gate behaviour from plain arithmetic on a,b in {0,1}.
  function automatic logic [5:0] truth(input int a, input int b);
    logic [5:0] t;
    t[0] = (a * b) == 1;
    t[1] = (a + b) >= 1;
    t[2] = a == 0;
    t[3] = (a * b) == 0;
    t[4] = (a + b) == 0;
    t[5] = (a + b) == 1;
    return t;
  endfunction

  function automatic logic [5:0] faulty(input logic a, input logic b,
                                        input logic [5:0] s, input logic [5:0] i);
    return (truth(int'(a), int'(b)) & ~s) ^ i;
  endfunction

  gate_truth_table_checker_if b0();
  gate_truth_table_checker_if b1();
  gate_truth_table_checker_if b2();

  gate_truth_table_checker #(.SETTLE_CYCLES(1), .STOP_ON_FAIL(0)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));
  gate_truth_table_checker #(.SETTLE_CYCLES(1), .STOP_ON_FAIL(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
  gate_truth_table_checker #(.SETTLE_CYCLES(3), .STOP_ON_FAIL(0)) u_dut2 (.clk(clk), .rst(rst), .bus(b2));

  assign b0.start = start_r[0];
  assign b1.start = start_r[1];
  assign b2.start = start_r[2];

  assign b0.gate_y = faulty(b0.stim_a, b0.stim_b, sa0[0], inv[0]);
  assign b1.gate_y = faulty(b1.stim_a, b1.stim_b, sa0[1], inv[1]);

  // Slow gate bank: outputs lag the stimulus by two clock cycles.
  logic [5:0] d1, d2;
  always @(posedge clk) begin
    d1 <= faulty(b2.stim_a, b2.stim_b, sa0[2], inv[2]);
    d2 <= d1;
  end
  assign b2.gate_y = d2;

  assign stim_w[0] = {b0.stim_a, b0.stim_b};
  assign stim_w[1] = {b1.stim_a, b1.stim_b};
  assign stim_w[2] = {b2.stim_a, b2.stim_b};
  assign busy_w[0] = b0.busy;       assign busy_w[1] = b1.busy;       assign busy_w[2] = b2.busy;
  assign done_w[0] = b0.done;       assign done_w[1] = b1.done;       assign done_w[2] = b2.done;
  assign pass_w[0] = b0.pass;       assign pass_w[1] = b1.pass;       assign pass_w[2] = b2.pass;
  assign fmask_w[0] = b0.fail_mask; assign fmask_w[1] = b1.fail_mask; assign fmask_w[2] = b2.fail_mask;
  assign fvec_w[0] = b0.fail_vec;   assign fvec_w[1] = b1.fail_vec;   assign fvec_w[2] = b2.fail_vec;
  assign fcnt_w[0] = b0.fail_count; assign fcnt_w[1] = b1.fail_count; assign fcnt_w[2] = b2.fail_count;

  // Trace of the most recent run (measurement only).
  logic [1:0] tr_stim [$];
  logic       tr_busy [$];
  int         tr_lat;
  logic [1:0] tr_done_stim;
  logic       tr_done_busy;
  logic       tr_after_done;

  // Reference model: walk the four vectors with the injected faults.
  task automatic predict(input logic [5:0] s, input logic [5:0] i, input bit stop,
                         output logic [5:0] fm, output logic [1:0] fv,
                         output int fc, output int nvec);
    logic [5:0] m;
    logic [1:0] vv;
    fm = 6'd0; fv = 2'b00; fc = 0; nvec = 0;
    for (int v = 0; v < 4; v++) begin
      vv = 2'(v);
      m = faulty(vv[1], vv[0], s, i) ^ truth(v / 2, v % 2);
      nvec++;
      if (fm == 6'd0 && m != 6'd0) fv = vv;
      fm = fm | m;
      fc = fc + $countones(m);
      if (stop && m != 6'd0) break;
    end
  endtask

  task automatic run_once(input int idx);
    @(negedge clk); start_r[idx] = 1'b1;
    @(negedge clk); start_r[idx] = 1'b0;
    tr_stim.delete(); tr_busy.delete(); tr_lat = 0;
    while (done_w[idx] !== 1'b1 && tr_lat < LIMIT) begin
      tr_stim.push_back(stim_w[idx]);
      tr_busy.push_back(busy_w[idx]);
      @(negedge clk);
      tr_lat++;
    end
    tr_done_stim = stim_w[idx];
    tr_done_busy = busy_w[idx];
    @(negedge clk);
    tr_after_done = done_w[idx];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++; if (busy_w[k] !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d]: got %b expected 0", k, busy_w[k]); end
      checks++; if (done_w[k] !== 1'b0) begin failures++; $display("FAIL reset_done[%0d]: got %b expected 0", k, done_w[k]); end
      checks++; if (pass_w[k] !== 1'b0) begin failures++; $display("FAIL reset_pass[%0d]: got %b expected 0", k, pass_w[k]); end
      checks++; if (stim_w[k] !== 2'b00) begin failures++; $display("FAIL reset_stim[%0d]: got %b expected 00", k, stim_w[k]); end
      checks++; if (fmask_w[k] !== 6'd0 || fvec_w[k] !== 2'd0 || fcnt_w[k] !== 5'd0) begin
        failures++; $display("FAIL reset_fail_regs[%0d]: got mask=%b vec=%b cnt=%0d expected all 0", k, fmask_w[k], fvec_w[k], fcnt_w[k]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_ideal();
    int bad;
    run_once(0);
    checks++; if (tr_lat !== 8) begin failures++; $display("FAIL ideal_latency: got %0d expected 8", tr_lat); end
    bad = 0;
    for (int k = 0; k < tr_lat; k++)
      if (tr_stim[k] !== 2'(k / 2) || tr_busy[k] !== 1'b1) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL ideal_stim_trace: got %0d bad cycles expected 0", bad); end
    checks++; if (tr_done_stim !== 2'b00 || tr_done_busy !== 1'b0) begin
      failures++; $display("FAIL ideal_done_outputs: got stim=%b busy=%b expected 00/0", tr_done_stim, tr_done_busy); end
    checks++; if (tr_after_done !== 1'b0) begin failures++; $display("FAIL ideal_done_pulse_width: got %b expected 0", tr_after_done); end
    checks++; if (pass_w[0] !== 1'b1 || fmask_w[0] !== 6'd0 || fcnt_w[0] !== 5'd0) begin
      failures++; $display("FAIL ideal_result: got pass=%b mask=%b cnt=%0d expected 1/0/0", pass_w[0], fmask_w[0], fcnt_w[0]); end
  endtask

  task automatic test_or_stuck();
    sa0[0] = 6'b000010;
    run_once(0);
    checks++; if (tr_lat !== 8) begin failures++; $display("FAIL or_latency: got %0d expected 8", tr_lat); end
    checks++; if (pass_w[0] !== 1'b0) begin failures++; $display("FAIL or_pass: got %b expected 0", pass_w[0]); end
    checks++; if (fmask_w[0] !== 6'b000010) begin failures++; $display("FAIL or_mask: got %b expected 000010", fmask_w[0]); end
    checks++; if (fvec_w[0] !== 2'b01) begin failures++; $display("FAIL or_vec: got %b expected 01", fvec_w[0]); end
    checks++; if (fcnt_w[0] !== 5'd3) begin failures++; $display("FAIL or_count: got %0d expected 3", fcnt_w[0]); end
    sa0[0] = 6'd0;
  endtask

  task automatic test_xor_stop();
    inv[1] = 6'b100000;
    run_once(1);
    checks++; if (tr_lat !== 2) begin failures++; $display("FAIL xor_stop_latency: got %0d expected 2", tr_lat); end
    checks++; if (fmask_w[1] !== 6'b100000 || fvec_w[1] !== 2'b00) begin
      failures++; $display("FAIL xor_stop_mask_vec: got %b/%b expected 100000/00", fmask_w[1], fvec_w[1]); end
    checks++; if (fcnt_w[1] !== 5'd1 || pass_w[1] !== 1'b0) begin
      failures++; $display("FAIL xor_stop_cnt_pass: got %0d/%b expected 1/0", fcnt_w[1], pass_w[1]); end
    inv[1] = 6'd0;
  endtask

  task automatic test_start_held();
    logic hb [15];
    logic hd [15];
    int bad, ndone;
    @(negedge clk); start_r[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin @(negedge clk); hb[k] = busy_w[0]; hd[k] = done_w[0]; end
    start_r[0] = 1'b0;
    for (int k = 10; k < 15; k++) begin @(negedge clk); hb[k] = busy_w[0]; hd[k] = done_w[0]; end
    bad = 0; ndone = 0;
    for (int k = 0; k < 15; k++) begin
      if (hb[k] !== (k < 8)) bad++;
      if (hd[k] === 1'b1) ndone++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL held_busy_pattern: got %0d bad cycles expected 0", bad); end
    checks++; if (ndone != 1) begin failures++; $display("FAIL held_done_count: got %0d expected 1", ndone); end
    checks++; if (hd[8] !== 1'b1) begin failures++; $display("FAIL held_done_position: got %b at cycle 8 expected 1", hd[8]); end
  endtask

  task automatic test_back_to_back();
    run_once(0);
    checks++; if (tr_lat !== 8 || pass_w[0] !== 1'b1) begin
      failures++; $display("FAIL b2b_run: got lat=%0d pass=%b expected 8/1", tr_lat, pass_w[0]); end
    run_once(0);
    checks++; if (tr_lat !== 8 || pass_w[0] !== 1'b1) begin
      failures++; $display("FAIL b2b_second_run: got lat=%0d pass=%b expected 8/1", tr_lat, pass_w[0]); end
  endtask

  task automatic test_midrun_reset();
    int n, ndone;
    sa0[0] = 6'b000010;
    @(negedge clk); start_r[0] = 1'b1;
    @(negedge clk); start_r[0] = 1'b0;
    n = 0;
    while (stim_w[0] !== 2'b10 && n < LIMIT) begin @(negedge clk); n++; end
    checks++; if (n >= LIMIT) begin failures++; $display("FAIL rst_reach_vec10: got timeout expected stim 10"); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy_w[0] !== 1'b0 || stim_w[0] !== 2'b00 || done_w[0] !== 1'b0) begin
      failures++; $display("FAIL rst_abort_outputs: got busy=%b stim=%b done=%b expected 0/00/0", busy_w[0], stim_w[0], done_w[0]); end
    checks++; if (fmask_w[0] !== 6'd0 || fcnt_w[0] !== 5'd0) begin
      failures++; $display("FAIL rst_abort_fail_regs: got mask=%b cnt=%0d expected 0/0", fmask_w[0], fcnt_w[0]); end
    rst = 1'b0;
    ndone = 0;
    repeat (10) begin @(negedge clk); if (done_w[0] === 1'b1 || busy_w[0] === 1'b1) ndone++; end
    checks++; if (ndone != 0) begin failures++; $display("FAIL rst_no_activity: got %0d active cycles expected 0", ndone); end
    sa0[0] = 6'd0;
    run_once(0);
    checks++; if (tr_lat !== 8 || pass_w[0] !== 1'b1 || fmask_w[0] !== 6'd0) begin
      failures++; $display("FAIL rst_clean_rerun: got lat=%0d pass=%b mask=%b expected 8/1/0", tr_lat, pass_w[0], fmask_w[0]); end
  endtask

  task automatic test_slow_gates();
    int bad;
    run_once(2);
    checks++; if (tr_lat !== 16) begin failures++; $display("FAIL slow_latency: got %0d expected 16", tr_lat); end
    bad = 0;
    for (int k = 0; k < tr_lat; k++)
      if (tr_stim[k] !== 2'(k / 4) || tr_busy[k] !== 1'b1) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL slow_stim_trace: got %0d bad cycles expected 0", bad); end
    checks++; if (pass_w[2] !== 1'b1 || fcnt_w[2] !== 5'd0) begin
      failures++; $display("FAIL slow_result: got pass=%b cnt=%0d expected 1/0", pass_w[2], fcnt_w[2]); end
  endtask

  task automatic test_random();
    logic [5:0] fm;
    logic [1:0] fv;
    int fc, nvec, idx;
    for (int it = 0; it < 15; it++) begin
      idx = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) begin
        sa0[idx] = 6'd0; inv[idx] = 6'd0;
      end else begin
        sa0[idx] = 6'($urandom); inv[idx] = 6'($urandom) & 6'($urandom);
      end
      predict(sa0[idx], inv[idx], stop_of[idx], fm, fv, fc, nvec);
      run_once(idx);
      checks++; if (tr_lat !== nvec * (settle_of[idx] + 1)) begin
        failures++; $display("FAIL rand%0d_latency: got %0d expected %0d", it, tr_lat, nvec * (settle_of[idx] + 1)); end
      checks++; if (fmask_w[idx] !== fm) begin failures++; $display("FAIL rand%0d_mask: got %b expected %b", it, fmask_w[idx], fm); end
      checks++; if (fvec_w[idx] !== fv) begin failures++; $display("FAIL rand%0d_vec: got %b expected %b", it, fvec_w[idx], fv); end
      checks++; if (fcnt_w[idx] !== 5'(fc)) begin failures++; $display("FAIL rand%0d_count: got %0d expected %0d", it, fcnt_w[idx], fc); end
      checks++; if (pass_w[idx] !== (fm == 6'd0)) begin failures++; $display("FAIL rand%0d_pass: got %b expected %b", it, pass_w[idx], fm == 6'd0); end
      sa0[idx] = 6'd0; inv[idx] = 6'd0;
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin start_r[k] = 1'b0; sa0[k] = 6'd0; inv[k] = 6'd0; end
    test_reset();
    test_ideal();
    test_or_stuck();
    test_xor_stop();
    test_start_held();
    test_back_to_back();
    test_midrun_reset();
    test_slow_gates();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
